// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipelined_barrel_shifter                                      |
// | Brief    : Pipelined log-shifter with LSR/ASR/LSL/ROR modes and tags.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipelined_barrel_shifter #(
  parameter int BIT_WIDTH        = 108,
  parameter int SHAMT_WIDTH      = 7,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_WIDTH        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH-1:0]   in_data,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  input  logic [1:0]             in_mode,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH-1:0]   out_data,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  localparam int NUM_STAGES = (SHAMT_WIDTH + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  localparam logic [1:0] c_mode_asr = 2'b01;
  localparam logic [1:0] c_mode_lsl = 2'b10;
  localparam logic [1:0] c_mode_ror = 2'b11;

  function automatic logic [BIT_WIDTH-1:0] f_rev(input logic [BIT_WIDTH-1:0] d);
    logic [BIT_WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < BIT_WIDTH; j++) begin
      r[j] = d[BIT_WIDTH-1-j];
    end
    return r;
  endfunction

  // One log-shifter level: right shift by k, refilling from the bottom on rotate.
  function automatic logic [BIT_WIDTH-1:0] f_level(input logic [BIT_WIDTH-1:0] d,
                                                   input int k,
                                                   input logic rot,
                                                   input logic fill);
    logic [BIT_WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < BIT_WIDTH; j++) begin
      if (j + k < BIT_WIDTH) begin
        r[j] = d[j+k];
      end else if (rot) begin
        r[j] = d[j+k-BIT_WIDTH];
      end else begin
        r[j] = fill;
      end
    end
    return r;
  endfunction

  logic                   w_adv;
  logic [BIT_WIDTH-1:0]   w_pre_data;
  logic [SHAMT_WIDTH-1:0] w_pre_shamt;
  logic                   w_pre_rot;
  logic                   w_pre_lsl;
  logic                   w_pre_fill;

  // LSL is done as a right shift on the bit-reversed operand; ROR folds the
  // amount into [0, BIT_WIDTH) so every later level is a plain rotate.
  always_comb begin
    w_pre_rot   = (in_mode == c_mode_ror);
    w_pre_lsl   = (in_mode == c_mode_lsl);
    w_pre_fill  = (in_mode == c_mode_asr) & in_data[BIT_WIDTH-1];
    w_pre_data  = w_pre_lsl ? f_rev(in_data) : in_data;
    w_pre_shamt = in_shamt;
    if (w_pre_rot && (32'(in_shamt) >= 32'(BIT_WIDTH))) begin
      w_pre_shamt = SHAMT_WIDTH'(32'(in_shamt) - 32'(BIT_WIDTH));
    end
  end

  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int c_lo   = s * LEVELS_PER_STAGE;
    localparam int c_hi   = ((s + 1) * LEVELS_PER_STAGE < SHAMT_WIDTH) ?
                            (s + 1) * LEVELS_PER_STAGE : SHAMT_WIDTH;
    localparam int c_nlev = c_hi - c_lo;
    localparam int c_win  = SHAMT_WIDTH - c_lo;
    localparam bit c_last = (s == NUM_STAGES - 1);

    logic                 w_vld;
    logic [BIT_WIDTH-1:0] w_src;
    logic [BIT_WIDTH-1:0] w_res;
    logic [TAG_WIDTH-1:0] w_tag;
    logic [c_win-1:0]     w_sh;
    logic                 w_rot;
    logic                 w_fill;
    logic                 w_lsl;

    logic                 r_vld;
    logic [BIT_WIDTH-1:0] r_data;
    logic [TAG_WIDTH-1:0] r_tag;

    if (s == 0) begin : g_src_in
      assign w_vld  = in_valid;
      assign w_src  = w_pre_data;
      assign w_tag  = in_tag;
      assign w_sh   = w_pre_shamt;
      assign w_rot  = w_pre_rot;
      assign w_fill = w_pre_fill;
      assign w_lsl  = w_pre_lsl;
    end else begin : g_src_prev
      assign w_vld  = g_stage[s-1].r_vld;
      assign w_src  = g_stage[s-1].r_data;
      assign w_tag  = g_stage[s-1].r_tag;
      assign w_sh   = g_stage[s-1].g_carry.r_sh;
      assign w_rot  = g_stage[s-1].g_carry.r_rot;
      assign w_fill = g_stage[s-1].g_carry.r_fill;
      assign w_lsl  = g_stage[s-1].g_carry.r_lsl;
    end

    always_comb begin
      w_res = w_src;
      for (int l = 0; l < c_nlev; l++) begin
        if (w_sh[l]) begin
          w_res = f_level(w_res, 1 << (c_lo + l), w_rot, w_fill);
        end
      end
      if (c_last && w_lsl) begin
        w_res = f_rev(w_res);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_data <= '0;
        r_tag  <= '0;
      end else if (w_adv) begin
        r_vld <= w_vld;
        if (w_vld) begin
          r_data <= w_res;
          r_tag  <= w_tag;
        end
      end
    end

    // Only the not-yet-consumed shift bits and mode flags travel onward.
    if (!c_last) begin : g_carry
      logic [c_win-c_nlev-1:0] r_sh;
      logic                    r_rot;
      logic                    r_fill;
      logic                    r_lsl;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sh   <= '0;
          r_rot  <= 1'b0;
          r_fill <= 1'b0;
          r_lsl  <= 1'b0;
        end else if (w_adv && w_vld) begin
          r_sh   <= w_sh[c_win-1:c_nlev];
          r_rot  <= w_rot;
          r_fill <= w_fill;
          r_lsl  <= w_lsl;
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_STAGES-1].r_vld;
  assign out_data  = g_stage[NUM_STAGES-1].r_data;
  assign out_tag   = g_stage[NUM_STAGES-1].r_tag;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipelined_barrel_shifter                                   |
// | Brief    : Directed and streaming checks of the pipelined barrel shifter.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pipelined_barrel_shifter;

  localparam int BW = 108;
  localparam int SW = 7;
  localparam int LPS = 2;
  localparam int TW = 8;
  localparam int NS = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [TW-1:0] out_tag;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  pipelined_barrel_shifter #(
    .BIT_WIDTH(BW),
    .SHAMT_WIDTH(SW),
    .LEVELS_PER_STAGE(LPS),
    .TAG_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_shamt(in_shamt),
    .in_mode(in_mode),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] model(input logic [BW-1:0] d, input int sh,
                                          input logic [1:0] m);
    int r;
    case (m)
      2'b00:   return (sh >= BW) ? '0 : d >> sh;
      2'b01:   return (sh >= BW) ? {BW{d[BW-1]}} : BW'($signed(d) >>> sh);
      2'b10:   return (sh >= BW) ? '0 : d << sh;
      default: begin
        r = (sh >= BW) ? sh - BW : sh;
        return (r == 0) ? d : ((d >> r) | (d << (BW - r)));
      end
    endcase
  endfunction

  // Single operand into an otherwise idle pipe; returns the result and latency.
  task automatic send_one(input logic [BW-1:0] d, input logic [SW-1:0] sh,
                          input logic [1:0] m, input logic [TW-1:0] t,
                          output logic [BW-1:0] rd, output logic [TW-1:0] rt,
                          output int lat);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_mode  = m;
    in_tag   = t;
    rd  = 'x;
    rt  = 'x;
    lat = -1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= NS + 4; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        rd  = out_data;
        rt  = out_tag;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = BW'(5);
    in_shamt = '0;
    in_mode = 2'b00;
    in_tag = 8'h11;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_tag !== '0) begin n_err++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== BW'(5) || out_tag !== 8'h11) begin
      n_err++; $display("FAIL fill_before_reset: got v=%b d=%h t=%h expected v=1 d=5 t=11", out_valid, out_data, out_tag);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL async_reset: got v=%b d=%h rdy=%b expected v=0 d=0 rdy=1", out_valid, out_data, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got out_valid=%b expected 0 at cycle %0d", out_valid, k); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lsr_lsl;
    logic [BW-1:0] d [6];
    logic [BW-1:0] e [6];
    logic [SW-1:0] sh [6];
    logic [1:0]    m [6];
    logic [BW-1:0] rd;
    logic [TW-1:0] rt;
    int lat;
    d[0] = BW'(1) << 107; sh[0] = 7'd107; m[0] = 2'b00; e[0] = BW'(1);
    d[1] = BW'(1);        sh[1] = 7'd107; m[1] = 2'b10; e[1] = BW'(1) << 107;
    d[2] = BW'(1) << 107; sh[2] = 7'd108; m[2] = 2'b00; e[2] = '0;
    d[3] = BW'(1);        sh[3] = 7'd108; m[3] = 2'b10; e[3] = '0;
    d[4] = 108'hABC;      sh[4] = 7'd4;   m[4] = 2'b00; e[4] = 108'hAB;
    d[5] = 108'hABC;      sh[5] = 7'd8;   m[5] = 2'b10; e[5] = 108'hABC00;
    for (int i = 0; i < 6; i++) begin
      send_one(d[i], sh[i], m[i], TW'(8'h20 + i), rd, rt, lat);
      n_vec++; if (rd !== e[i] || rt !== TW'(8'h20 + i)) begin
        n_err++; $display("FAIL lsr_lsl[%0d]: got d=%h t=%h expected d=%h t=%h", i, rd, rt, e[i], TW'(8'h20 + i));
      end
      n_vec++; if (lat !== NS) begin n_err++; $display("FAIL latency[%0d]: got %0d expected %0d", i, lat, NS); end
    end
  endtask

  task automatic test_asr;
    logic [BW-1:0] d [5];
    logic [BW-1:0] e [5];
    logic [SW-1:0] sh [5];
    logic [BW-1:0] rd;
    logic [TW-1:0] rt;
    int lat;
    d[0] = {1'b1, 107'b0};      sh[0] = 7'd100; e[0] = {{101{1'b1}}, 7'b0};
    d[1] = {1'b1, 107'b0};      sh[1] = 7'd127; e[1] = {BW{1'b1}};
    d[2] = {1'b0, {107{1'b1}}}; sh[2] = 7'd127; e[2] = '0;
    d[3] = {1'b0, {107{1'b1}}}; sh[3] = 7'd3;   e[3] = {4'b0, {104{1'b1}}};
    d[4] = 108'hF00;            sh[4] = 7'd0;   e[4] = 108'hF00;
    for (int i = 0; i < 5; i++) begin
      send_one(d[i], sh[i], 2'b01, TW'(8'h40 + i), rd, rt, lat);
      n_vec++; if (rd !== e[i] || rt !== TW'(8'h40 + i)) begin
        n_err++; $display("FAIL asr[%0d]: got d=%h t=%h expected d=%h t=%h", i, rd, rt, e[i], TW'(8'h40 + i));
      end
    end
  endtask

  task automatic test_ror;
    logic [BW-1:0] d [5];
    logic [BW-1:0] e [5];
    logic [SW-1:0] sh [5];
    logic [BW-1:0] rd;
    logic [TW-1:0] rt;
    int lat;
    d[0] = BW'(1);   sh[0] = 7'd1;   e[0] = BW'(1) << 107;
    d[1] = BW'(1);   sh[1] = 7'd109; e[1] = BW'(1) << 107;
    d[2] = BW'(1);   sh[2] = 7'd0;   e[2] = BW'(1);
    d[3] = BW'(3);   sh[3] = 7'd108; e[3] = BW'(3);
    d[4] = 108'hF;   sh[4] = 7'd2;   e[4] = (BW'(3) << 106) | BW'(3);
    for (int i = 0; i < 5; i++) begin
      send_one(d[i], sh[i], 2'b11, TW'(8'h60 + i), rd, rt, lat);
      n_vec++; if (rd !== e[i] || rt !== TW'(8'h60 + i)) begin
        n_err++; $display("FAIL ror[%0d]: got d=%h t=%h expected d=%h t=%h", i, rd, rt, e[i], TW'(8'h60 + i));
      end
    end
  endtask

  // Ten back-to-back mixed-mode operands with a three-cycle output stall.
  task automatic test_back_to_back;
    exp_q.delete();
    out_ready = 1'b1;
    fork
      begin : drive
        for (int i = 0; i < 10; i++) begin
          logic acc;
          acc = 1'b0;
          in_valid = 1'b1;
          in_data  = BW'({$urandom(), $urandom(), $urandom(), $urandom()});
          in_shamt = SW'($urandom_range(0, 127));
          in_mode  = 2'($urandom_range(0, 3));
          in_tag   = TW'(i);
          for (int w = 0; w < 50 && !acc; w++) begin
            @(negedge clk);
            if (in_ready) begin
              exp_q.push_back('{model(in_data, int'(in_shamt), in_mode), TW'(i)});
              acc = 1'b1;
            end
            @(posedge clk);
            #1;
          end
          if (!acc) begin n_vec++; n_err++; $display("FAIL b2b_accept_timeout: got no in_ready expected accept of op %0d", i); end
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int got;
        int cyc;
        bit stalled;
        exp_t ex;
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        while (got < 10 && cyc < 200) begin
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            ex = (exp_q.size() > 0) ? exp_q.pop_front() : '{default: 'x};
            n_vec++; if (out_data !== ex.data || out_tag !== TW'(got)) begin
              n_err++; $display("FAIL b2b_result[%0d]: got d=%h t=%h expected d=%h t=%h", got, out_data, out_tag, ex.data, TW'(got));
            end
            got++;
          end
          @(posedge clk);
          #1;
          if (got == 3 && !stalled) begin
            stalled = 1'b1;
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
              @(negedge clk);
              n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== TW'(3)) begin
                n_err++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b t=%h expected rdy=0 v=1 t=03", k, in_ready, out_valid, out_tag);
              end
              @(posedge clk);
              #1;
            end
            out_ready = 1'b1;
          end
        end
        n_vec++; if (got != 10 || exp_q.size() != 0) begin
          n_err++; $display("FAIL b2b_count: got %0d results (%0d left) expected 10 (0 left)", got, exp_q.size());
        end
      end
    join
  endtask

  task automatic test_random;
    localparam int N = 10000;
    exp_q.delete();
    fork
      begin : drive
        int sent;
        int cyc;
        sent = 0;
        cyc = 0;
        while (sent < N && cyc < 60000) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = BW'({$urandom(), $urandom(), $urandom(), $urandom()});
          in_shamt = SW'($urandom_range(0, 127));
          in_mode  = 2'($urandom_range(0, 3));
          in_tag   = TW'(sent);
          @(negedge clk);
          if (in_valid && in_ready) begin
            exp_q.push_back('{model(in_data, int'(in_shamt), in_mode), in_tag});
            sent++;
          end
          @(posedge clk);
          #1;
          cyc++;
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int got;
        int cyc;
        exp_t ex;
        got = 0;
        cyc = 0;
        while (got < N && cyc < 70000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (out_valid && out_ready) begin
            ex = (exp_q.size() > 0) ? exp_q.pop_front() : '{default: 'x};
            n_vec++; if (out_data !== ex.data || out_tag !== ex.tag) begin
              n_err++; $display("FAIL random[%0d]: got d=%h t=%h expected d=%h t=%h", got, out_data, out_tag, ex.data, ex.tag);
            end
            got++;
          end
          @(posedge clk);
          #1;
          cyc++;
        end
        out_ready = 1'b1;
        n_vec++; if (got != N || exp_q.size() != 0) begin
          n_err++; $display("FAIL random_count: got %0d results (%0d left) expected %0d (0 left)", got, exp_q.size(), N);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_lsr_lsl();
    test_asr();
    test_ror();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
